// File: rtl/axil_read_arbiter.sv
// ---------------------------------------------------------------------------
// axil_read_arbiter
//
// Lets NUM_REQ AXI4-Lite read requesters share one downstream read-only slave
// port. Arbitration is round-robin, and only one read may be outstanding: an
// accepted AR whose R beat has not yet been delivered blocks the next grant.
//
// Ports
//   clk_i        system clock, rising edge
//   rst_i        synchronous active-high reset
//   s_araddr_i   requester read addresses, requester k at [k*ADDR_W +: ADDR_W]
//   s_arvalid_i  per-requester AR valid
//   s_arready_o  per-requester AR ready (one-cycle pulse to the winner in IDLE)
//   s_rdata_o    read data, broadcast to all requesters
//   s_rresp_o    read response, broadcast to all requesters
//   s_rvalid_o   per-requester R valid (only the granted bit can be set)
//   s_rready_i   per-requester R ready
//   m_araddr_o   downstream read address (registered)
//   m_arvalid_o  downstream AR valid (registered)
//   m_arready_i  downstream AR ready
//   m_rdata_i    downstream read data
//   m_rresp_i    downstream read response
//   m_rvalid_i   downstream R valid
//   m_rready_o   downstream R ready (combinational from the granted requester)
//   busy_o       high from the cycle after grant until the R handshake is done
// ---------------------------------------------------------------------------
module axil_read_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NUM_REQ*ADDR_W-1:0] s_araddr_i,
    input  logic [NUM_REQ-1:0]        s_arvalid_i,
    output logic [NUM_REQ-1:0]        s_arready_o,
    output logic [DATA_W-1:0]         s_rdata_o,
    output logic [1:0]                s_rresp_o,
    output logic [NUM_REQ-1:0]        s_rvalid_o,
    input  logic [NUM_REQ-1:0]        s_rready_i,
    output logic [ADDR_W-1:0]         m_araddr_o,
    output logic                      m_arvalid_o,
    input  logic                      m_arready_i,
    input  logic [DATA_W-1:0]         m_rdata_i,
    input  logic [1:0]                m_rresp_i,
    input  logic                      m_rvalid_i,
    output logic                      m_rready_o,
    output logic                      busy_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t               state_reg;
    logic [IDX_W-1:0]     rr_ptr_reg;
    logic [IDX_W-1:0]     grant_reg;
    logic [NUM_REQ-1:0]   grant_oh_reg;
    logic [ADDR_W-1:0]    araddr_reg;
    logic                 arvalid_reg;

    logic                 pick_valid;
    logic [IDX_W-1:0]     pick_idx;
    logic [ADDR_W-1:0]    pick_addr;
    logic [NUM_REQ-1:0]   pick_oh;
    logic                 r_ready_sel;
    logic                 r_done;
    logic [IDX_W-1:0]     rr_ptr_next;

    // Round-robin pick: each requesting bit gets its distance from rr_ptr
    // (modulo NUM_REQ); the smallest distance wins. Looping over constant
    // requester indices keeps the address mux free of variable part-selects.
    always_comb begin
        int best_off;
        int off;
        pick_valid = 1'b0;
        pick_idx   = '0;
        pick_addr  = '0;
        best_off   = NUM_REQ;
        off        = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            off = k - int'(rr_ptr_reg);
            if (off < 0) begin
                off = off + NUM_REQ;
            end
            if (s_arvalid_i[k] && (off < best_off)) begin
                best_off   = off;
                pick_valid = 1'b1;
                pick_idx   = IDX_W'(k);
                pick_addr  = s_araddr_i[k*ADDR_W +: ADDR_W];
            end
        end
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        assign pick_oh[gi]     = pick_valid && (pick_idx == IDX_W'(gi));
        // The AR handshake with the winner happens in the IDLE cycle itself;
        // suppressed during reset so no handshake completes while resetting.
        assign s_arready_o[gi] = (state_reg == IDLE) && !rst_i && pick_oh[gi];
        assign s_rvalid_o[gi]  = (state_reg == DATA) && grant_oh_reg[gi] && m_rvalid_i;
    end

    assign r_ready_sel = |(s_rready_i & grant_oh_reg);
    assign m_rready_o  = (state_reg == DATA) && r_ready_sel;
    assign r_done      = m_rvalid_i && r_ready_sel;
    assign rr_ptr_next = (grant_reg == IDX_W'(NUM_REQ - 1)) ? '0 : grant_reg + 1'b1;

    assign s_rdata_o   = m_rdata_i;
    assign s_rresp_o   = m_rresp_i;
    assign m_araddr_o  = araddr_reg;
    assign m_arvalid_o = arvalid_reg;
    assign busy_o      = (state_reg != IDLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg    <= IDLE;
            rr_ptr_reg   <= '0;
            grant_reg    <= '0;
            grant_oh_reg <= '0;
            araddr_reg   <= '0;
            arvalid_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pick_valid) begin
                        grant_reg    <= pick_idx;
                        grant_oh_reg <= pick_oh;
                        araddr_reg   <= pick_addr;
                        arvalid_reg  <= 1'b1;
                        state_reg    <= ADDR;
                    end
                end
                ADDR: begin
                    if (m_arready_i) begin
                        arvalid_reg <= 1'b0;
                        state_reg   <= DATA;
                    end
                end
                DATA: begin
                    if (r_done) begin
                        rr_ptr_reg <= rr_ptr_next;
                        state_reg  <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axil_read_arbiter.sv
module tb_axil_read_arbiter;

    localparam int N = 3;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic [N*32-1:0] s_araddr_i;
    logic [N-1:0]    s_arvalid_i;
    logic [N-1:0]    s_arready_o;
    logic [31:0]     s_rdata_o;
    logic [1:0]      s_rresp_o;
    logic [N-1:0]    s_rvalid_o;
    logic [N-1:0]    s_rready_i;
    logic [31:0]     m_araddr_o;
    logic            m_arvalid_o;
    logic            m_arready_i;
    logic [31:0]     m_rdata_i;
    logic [1:0]      m_rresp_i;
    logic            m_rvalid_i;
    logic            m_rready_o;
    logic            busy_o;

    axil_read_arbiter #(.NUM_REQ(N), .ADDR_W(32), .DATA_W(32)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .s_araddr_i  (s_araddr_i),
        .s_arvalid_i (s_arvalid_i),
        .s_arready_o (s_arready_o),
        .s_rdata_o   (s_rdata_o),
        .s_rresp_o   (s_rresp_o),
        .s_rvalid_o  (s_rvalid_o),
        .s_rready_i  (s_rready_i),
        .m_araddr_o  (m_araddr_o),
        .m_arvalid_o (m_arvalid_o),
        .m_arready_i (m_arready_i),
        .m_rdata_i   (m_rdata_i),
        .m_rresp_i   (m_rresp_i),
        .m_rvalid_i  (m_rvalid_i),
        .m_rready_o  (m_rready_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [2:0]  add;     // requesters that raise arvalid before this read
        logic [31:0] abase;   // requester k of a new request uses abase + 4*k
        int          ard;     // cycles m_arready_i is held low
        int          rvd;     // cycles before m_rvalid_i rises
        int          rd;      // cycles the granted requester holds rready low
        logic [31:0] rdata;
        logic [1:0]  rresp;
        int          exp_g;   // expected grant
    } vec_t;

    vec_t        vecs [14];
    int          total  = 0;
    int          passed = 0;
    int          txn    = 0;
    logic [2:0]  pending = '0;
    logic [31:0] addr_m [N];
    int          ptr_m  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL txn%0d %s: got %h expected %h", txn, name, act, exp);
    endtask

    // Reference arbiter: first pending requester at or after the pointer.
    function automatic int model_pick();
        for (int off = 0; off < N; off++) begin
            if (pending[(ptr_m + off) % N]) return (ptr_m + off) % N;
        end
        return -1;
    endfunction

    task automatic drive_addrs();
        for (int k = 0; k < N; k++) s_araddr_i[k*32 +: 32] = addr_m[k];
    endtask

    // One full read: IDLE capture, ADDR wait, DATA with backpressure.
    task automatic run_txn(input vec_t v, input bit use_model);
        int         g;
        logic [2:0] oh;
        int         last;
        for (int k = 0; k < N; k++) begin
            if (v.add[k] && !pending[k]) addr_m[k] = v.abase + 32'(4 * k);
        end
        pending = pending | v.add;
        g  = use_model ? model_pick() : v.exp_g;
        oh = 3'b001 << g;

        @(negedge clk_i);
        s_arvalid_i = pending; drive_addrs();
        m_arready_i = 1'b0; m_rvalid_i = 1'b0; s_rready_i = '0;
        #1;
        chk("idle_busy", 64'(busy_o), 64'd0);
        chk("idle_m_arvalid", 64'(m_arvalid_o), 64'd0);
        chk("grant_arready", 64'(s_arready_o), 64'(oh));
        pending[g] = 1'b0;

        for (int i = 0; i <= v.ard; i++) begin
            @(negedge clk_i);
            s_arvalid_i = pending;
            m_arready_i = (i == v.ard);
            #1;
            chk("addr_busy", 64'(busy_o), 64'd1);
            chk("addr_m_arvalid", 64'(m_arvalid_o), 64'd1);
            chk("addr_m_araddr", 64'(m_araddr_o), 64'(addr_m[g]));
            chk("addr_no_arready", 64'(s_arready_o), 64'd0);
        end

        last = v.rvd + v.rd;
        for (int j = 0; j <= last; j++) begin
            @(negedge clk_i);
            m_arready_i = 1'b0;
            m_rvalid_i  = (j >= v.rvd);
            m_rdata_i   = m_rvalid_i ? v.rdata : $urandom;
            m_rresp_i   = m_rvalid_i ? v.rresp : 2'($urandom);
            s_rready_i  = (j == last) ? 3'b111 : ~oh;
            #1;
            chk("data_busy", 64'(busy_o), 64'd1);
            chk("data_m_arvalid", 64'(m_arvalid_o), 64'd0);
            chk("data_s_rvalid", 64'(s_rvalid_o), m_rvalid_i ? 64'(oh) : 64'd0);
            chk("data_m_rready", 64'(m_rready_o), 64'(j == last));
            if (j == last) begin
                chk("data_rdata", 64'(s_rdata_o), 64'(v.rdata));
                chk("data_rresp", 64'(s_rresp_o), 64'(v.rresp));
            end
        end
        ptr_m = (g + 1) % N;
        $display("txn%0d grant=%0d addr=%h rdata=%h rresp=%0d ard=%0d rvd=%0d rd=%0d",
                 txn, g, addr_m[g], v.rdata, v.rresp, v.ard, v.rvd, v.rd);
        txn++;
    endtask

    initial begin
        vec_t rv;
        vecs[0]  = '{3'b001, 32'h1000_0000, 1, 0, 0, 32'hDEAD_BEEF, 2'b00, 0};
        vecs[1]  = '{3'b010, 32'h2000_0000, 0, 0, 0, 32'h1111_1111, 2'b00, 1};
        vecs[2]  = '{3'b011, 32'h3000_0000, 0, 1, 0, 32'h2222_2222, 2'b00, 0};
        vecs[3]  = '{3'b000, 32'h0000_0000, 0, 0, 1, 32'h3333_3333, 2'b00, 1};
        vecs[4]  = '{3'b011, 32'h4000_0000, 2, 0, 0, 32'h4444_4444, 2'b00, 0};
        vecs[5]  = '{3'b001, 32'h5000_0000, 0, 0, 0, 32'h5555_5555, 2'b00, 1};
        vecs[6]  = '{3'b010, 32'h6000_0000, 0, 0, 0, 32'h6666_6666, 2'b00, 0};
        vecs[7]  = '{3'b001, 32'h7000_0000, 0, 0, 0, 32'h7777_7777, 2'b00, 1};
        vecs[8]  = '{3'b100, 32'h8000_0000, 0, 0, 0, 32'h8888_8888, 2'b00, 2};
        vecs[9]  = '{3'b010, 32'h9000_0000, 0, 0, 0, 32'h9999_9999, 2'b00, 0};
        vecs[10] = '{3'b000, 32'h0000_0000, 0, 0, 0, 32'hAAAA_AAAA, 2'b00, 1};
        vecs[11] = '{3'b001, 32'hA000_0000, 5, 1, 3, 32'hCAFE_F00D, 2'b00, 0};
        vecs[12] = '{3'b010, 32'hB000_0000, 0, 0, 0, 32'h0BAD_0BAD, 2'b10, 1};
        vecs[13] = '{3'b111, 32'hC000_0000, 1, 2, 1, 32'h1234_5678, 2'b11, 2};
        for (int k = 0; k < N; k++) addr_m[k] = '0;

        rst_i = 1'b1; s_arvalid_i = '0; s_rready_i = '0; drive_addrs();
        m_arready_i = 1'b0; m_rvalid_i = 1'b0; m_rdata_i = '0; m_rresp_i = '0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_m_arvalid", 64'(m_arvalid_o), 64'd0);
        chk("rst_m_araddr", 64'(m_araddr_o), 64'd0);
        chk("rst_s_rvalid", 64'(s_rvalid_o), 64'd0);
        chk("rst_m_rready", 64'(m_rready_o), 64'd0);
        chk("rst_s_arready", 64'(s_arready_o), 64'd0);

        for (int i = 0; i < 14; i++) run_txn(vecs[i], 1'b0);

        // Reset in DATA with the pointer at 2; the aborted read must vanish.
        pending = '0;
        rv = '{3'b010, 32'hD000_0000, 0, 0, 0, 32'h0F0F_0F0F, 2'b00, 1};
        run_txn(rv, 1'b0);
        @(negedge clk_i);
        addr_m[0] = 32'hE000_0000; drive_addrs();
        s_arvalid_i = 3'b001; s_rready_i = '0; m_rvalid_i = 1'b0;
        #1;
        chk("abort_arready", 64'(s_arready_o), 64'd1);
        @(negedge clk_i);
        s_arvalid_i = '0; m_arready_i = 1'b1;
        @(negedge clk_i);
        m_arready_i = 1'b0;
        #1;
        chk("abort_in_data", 64'(busy_o), 64'd1);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0; s_rready_i = 3'b111;
        #1;
        chk("abort_busy", 64'(busy_o), 64'd0);
        chk("abort_m_arvalid", 64'(m_arvalid_o), 64'd0);
        chk("abort_m_araddr", 64'(m_araddr_o), 64'd0);
        chk("abort_s_rvalid", 64'(s_rvalid_o), 64'd0);
        chk("abort_m_rready", 64'(m_rready_o), 64'd0);
        chk("abort_s_arready", 64'(s_arready_o), 64'd0);
        $display("txn%0d reset in DATA, read abandoned", txn);
        txn++;
        pending = '0; ptr_m = 0;
        // With the pointer back at 0, req1 beats req2.
        rv = '{3'b110, 32'hF000_0000, 1, 1, 1, 32'h5A5A_A5A5, 2'b00, 1};
        run_txn(rv, 1'b0);

        for (int i = 0; i < 40; i++) begin
            rv.add = 3'($urandom_range(0, 7));
            if ((pending | rv.add) == 3'b000) rv.add = 3'b001 << $urandom_range(0, 2);
            rv.abase = $urandom & 32'hFFFF_FFF0;
            rv.ard   = $urandom_range(0, 3);
            rv.rvd   = $urandom_range(0, 2);
            rv.rd    = $urandom_range(0, 3);
            rv.rdata = $urandom;
            rv.rresp = 2'($urandom);
            rv.exp_g = 0;
            run_txn(rv, 1'b1);
        end

        @(negedge clk_i);
        s_arvalid_i = '0; m_rvalid_i = 1'b0; s_rready_i = '0;
        #1;
        chk("final_busy", 64'(busy_o), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/axil_read_arbiter.md
Name: axil_read_arbiter

Overview:
- Shares one AXI4-Lite read-only slave port (boot ROM / soft memory read path) between NUM_REQ requesters, e.g. core instruction fetch, core data port and the debug module.
- Round-robin arbitration with exactly one outstanding read (AR accepted, R not yet delivered) at a time.
- Sits between the core-side AXI4-Lite bridges and the memory interconnect.
- Widths follow the AXI4-Lite configuration: 32-bit address, 32-bit data.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ADDR_W, 32, AXI4-Lite address width (AXI4L_CONF_ADDR_WIDTH)
DATA_W, 32, AXI4-Lite data width (AXI4L_CONF_DATA_WIDTH)

Ports:
clk_i  in  1  system clock, all logic on rising edge
rst_i  in  1  synchronous active-high reset
s_araddr_i  in  NUM_REQ*ADDR_W  requester read addresses, requester k at bits [k*ADDR_W +: ADDR_W]
s_arvalid_i  in  NUM_REQ  per-requester AR valid
s_arready_o  out  NUM_REQ  per-requester AR ready
s_rdata_o  out  DATA_W  read data, broadcast to all requesters
s_rresp_o  out  2  read response, broadcast
s_rvalid_o  out  NUM_REQ  per-requester R valid; only granted bit may be 1
s_rready_i  in  NUM_REQ  per-requester R ready
m_araddr_o  out  ADDR_W  downstream read address
m_arvalid_o  out  1  downstream AR valid
m_arready_i  in  1  downstream AR ready
m_rdata_i  in  DATA_W  downstream read data
m_rresp_i  in  2  downstream read response
m_rvalid_i  in  1  downstream R valid
m_rready_o  out  1  downstream R ready
busy_o  out  1  high from grant until R handshake completes

Behaviour:
- Interface: one clock (clk_i); reset rst_i is synchronous and active-high.
- Reset: state=IDLE, rr_ptr=0, grant index=0, m_arvalid_o=0, m_araddr_o=0, all s_arready_o=0, all s_rvalid_o=0, m_rready_o=0, busy_o=0. Reset mid-transaction abandons it without completing any handshake. The system resets the downstream slave in the same cycle.
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - If any s_arvalid_i is set, pick the first set bit searching from rr_ptr upward, modulo NUM_REQ.
  - Register the grant index and its s_araddr_i into m_araddr_o.
  - Pulse s_arready_o[grant]=1 for that single cycle. The AR is captured when the handshake occurs in this cycle.
  - Next state ADDR; busy_o=1 from next cycle.
  - If no s_arvalid_i is set, stay in IDLE.
- ADDR:
  - m_arvalid_o=1 and m_araddr_o are held stable until m_arready_i.
  - On the handshake, m_arvalid_o drops the next cycle. Next state DATA.
- DATA:
  - s_rvalid_o[grant]=m_rvalid_i; all other s_rvalid_o bits are 0.
  - m_rready_o=s_rready_i[grant]. This path is combinational: zero added latency on R.
  - s_rdata_o=m_rdata_i and s_rresp_o=m_rresp_i. Both are don't-care when no s_rvalid_o bit is set.
  - On the R handshake (m_rvalid_i & s_rready_i[grant]), set rr_ptr=(grant+1) mod NUM_REQ and go to IDLE; busy_o=0 next cycle.
- Latency: the minimum AR path is 2 cycles from s_arvalid_i to m_arvalid_o (IDLE capture, then ADDR). The minimum back-to-back issue interval is IDLE→ADDR→DATA→IDLE = 3 cycles plus slave latency.
- Fairness: a requester holding s_arvalid_i is granted within NUM_REQ transactions.
- Simultaneous requests: resolved by rr_ptr only; no fixed priority.
- Granted requester dropping s_rready_i: the arbiter waits indefinitely in DATA, with no timeout.
- Non-granted requesters: their s_arready_o stays 0 while busy. Requests from them are held, never dropped.
- Protocol rule: s_arvalid_i must stay high until ready, per AXI. A requester deasserting early before grant is simply not considered.
- m_rresp_i is passed through unmodified; SLVERR/DECERR are not altered.
- NUM_REQ=1 degenerates to a pipeline register on AR with rr_ptr fixed at 0.

Test Plan:
- Single read: req0 araddr=0x1000_0000; slave arready after 1 cycle, rdata=0xDEAD_BEEF, rresp=0 → s_rvalid_o=2'b01, s_rdata_o=0xDEAD_BEEF, busy_o drops one cycle after the R handshake.
- Contention: req0 and req1 assert in the same cycle, held continuously, 4 reads each → grant order 0,1,0,1,0,1,0,1; m_araddr_o alternates between their addresses.
- Round-robin pointer: after a req1 transaction, req0 and req1 both request → req0 granted first. Repeat with NUM_REQ=3 and req2 last served → order 0,1.
- Backpressure: m_arready_i low 5 cycles, then requester rready low 3 cycles after rvalid → m_araddr_o stable for all 5 cycles; m_rready_o low for 3 cycles; exactly one R beat delivered; no s_rvalid_o on the other requester.
- Error passthrough: slave returns rresp=2'b10 → s_rresp_o=2'b10 on the granted requester only.
- Reset mid-operation: rst_i asserted in DATA with m_rvalid_i low → next cycle all outputs at reset values, rr_ptr=0; a new req1 read completes normally afterwards.
